fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter address_data, default 32, giving the width of the PC, address and instruction buses.
REQ-002 SHALL have parameter reset_pc, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, which holds the PC and the IF/ID register.
REQ-006 SHALL have port flush, input, 1, which inserts a bubble into IF/ID.
REQ-007 SHALL have port branch_taken, input, 1, which redirects the PC to branch_target.
REQ-008 SHALL have port branch_target, input, address_data, the branch destination byte address.
REQ-009 SHALL have port jump, input, 1, which redirects the PC to the J-type target.
REQ-010 SHALL have port jump_index, input, 26, the J-type instruction index field.
REQ-011 SHALL have port i_in, input, address_data, the instruction returned combinationally by instruction memory for address.
REQ-012 SHALL have port address, output, address_data, the current PC driven to instruction memory.
REQ-013 SHALL have port instr, output, address_data, the IF/ID registered instruction.
REQ-014 SHALL have port pc_plus4, output, address_data, the IF/ID registered PC+4 of instr.
REQ-015 SHALL have port valid, output, 1, the IF/ID entry holding a real (non-bubble) instruction.

Function
REQ-016 SHALL hold the PC in an address_data-bit register and drive address directly from that register (no combinational path from inputs to address).
REQ-017 SHALL select the next PC in this priority order: reset, then jump, then branch_taken, then stall, then sequential.
REQ-018 On jump=1, SHALL load PC <= {pc_plus4[31:28], jump_index, 2'b00}, using the registered IF/ID pc_plus4.
REQ-019 On branch_taken=1 with jump=0, SHALL load PC <= {branch_target[31:2], 2'b00}; bits [1:0] are always forced to zero.
REQ-020 On stall=1 with no redirect, SHALL keep PC, instr, pc_plus4 and valid unchanged.
REQ-021 Otherwise, SHALL load PC <= PC + 4, computed modulo 2^address_data (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-022 On each non-stalled, non-redirect, non-flush cycle, SHALL capture instr <= i_in, pc_plus4 <= PC + 4 and valid <= 1.
REQ-023 On jump or branch_taken, SHALL load IF/ID with a bubble (instr=0, pc_plus4=0, valid=0), discarding the wrong-path fetch.
REQ-024 On flush=1, SHALL load IF/ID with a bubble; flush alone SHALL NOT alter the PC sequencing given by REQ-017..REQ-021.
REQ-025 A redirect SHALL override stall in the same cycle: the PC is redirected and IF/ID receives a bubble.
REQ-026 When flush and stall are both 1 with no redirect, SHALL hold the PC and bubble IF/ID.
REQ-027 Latency: an instruction at PC appears on instr one clock after address=PC, with a redirect costing exactly one bubble.
REQ-028 All outputs SHALL be registers; the block SHALL contain no combinational path from any input to any output.

Reset
REQ-029 While reset=1 at a rising edge, SHALL set PC=reset_pc, instr=0, pc_plus4=0 and valid=0, regardless of all other inputs.
REQ-030 Reset asserted mid-operation, including during stall or a redirect, SHALL take effect at the next edge with no residual state.
REQ-031 On the first edge after reset deasserts, SHALL fetch normally: valid=1, instr=rom[reset_pc>>2], PC=reset_pc+4.

Verification
REQ-032 Reset then 3 free-run cycles, ROM word0=A, word1=B, word2=C -> address 0,4,8,12; instr A,B,C; pc_plus4 4,8,12; valid 1.
REQ-033 With PC=8, stall=1 for 2 cycles -> address stays 8 and instr/pc_plus4/valid are frozen; after release, PC=12 next edge.
REQ-034 With PC=16, branch_taken=1 and branch_target=32'h0000_0043 -> next PC=32'h40, valid=0 for one cycle, then instr=rom[16].
REQ-035 With pc_plus4=32'h1000_0008, jump=1, jump_index=26'h0000010 and branch_taken=1 simultaneously -> PC=32'h1000_0040 (jump wins), bubble inserted.
REQ-036 With PC=32'hFFFF_FFFC free-running -> next PC=32'h0000_0000 and pc_plus4=32'h0000_0000.
REQ-037 Reset asserted during stall=1 and branch_taken=1 -> PC=reset_pc, valid=0, instr=0 on that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with jump/branch redirect.
// Latency: instr for PC appears one clock after address=PC; a redirect costs exactly one bubble.
// Backpressure: stall holds PC and IF/ID; a redirect overrides stall; flush bubbles IF/ID only.
module fetch_stage #(
   parameter int                    address_data = 32,
   parameter logic [address_data-1:0] reset_pc   = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    branch_taken,
   input  logic [address_data-1:0] branch_target,
   input  logic                    jump,
   input  logic [25:0]             jump_index,
   input  logic [address_data-1:0] i_in,
   output logic [address_data-1:0] address,
   output logic [address_data-1:0] instr,
   output logic [address_data-1:0] pc_plus4,
   output logic                    valid
);

   logic [address_data-1:0] pc_q, pc_d;
   logic [address_data-1:0] instr_q, instr_d;
   logic [address_data-1:0] pc_plus4_q, pc_plus4_d;
   logic                    valid_q, valid_d;

   logic [address_data-1:0] pc_seq;
   logic [address_data-1:0] jump_pc;
   logic [address_data-1:0] branch_pc;
   logic                    redirect;

   // Candidate next-PC values; the jump region comes from the PC+4 of the instruction in IF/ID
   always_comb begin
      pc_seq    = pc_q + address_data'(4);
      jump_pc   = {pc_plus4_q[address_data-1:28], jump_index, 2'b00};
      branch_pc = {branch_target[address_data-1:2], 2'b00};
      redirect  = jump | branch_taken;
   end

   // Next-state selection: jump beats branch beats stall beats sequential; bubble on redirect or flush
   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;

      if (jump) begin
         pc_d = jump_pc;
      end else if (branch_taken) begin
         pc_d = branch_pc;
      end else if (!stall) begin
         pc_d = pc_seq;
      end

      if (redirect || flush) begin
         instr_d    = '0;
         pc_plus4_d = '0;
         valid_d    = 1'b0;
      end else if (!stall) begin
         instr_d    = i_in;
         pc_plus4_d = pc_seq;
         valid_d    = 1'b1;
      end
   end

   // State registers with synchronous reset that dominates every other input
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= reset_pc;
         instr_q    <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign address  = pc_q;
   assign instr    = instr_q;
   assign pc_plus4 = pc_plus4_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a reference model.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: stall, flush and redirects are driven directly by the bench.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset, stall, flush, branch_taken, jump;
   logic [31:0] branch_target, i_in, address, instr, pc_plus4;
   logic [25:0] jump_index;
   logic        valid;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: architectural view of PC and IF/ID
   logic [31:0] m_pc, m_instr, m_pp4;
   logic        m_valid;

   fetch_stage #(.address_data(32), .reset_pc(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_index(jump_index), .i_in(i_in),
      .address(address), .instr(instr), .pc_plus4(pc_plus4), .valid(valid)
   );

   always #5 clock = ~clock;

   // instruction memory contents: a scrambled, never-zero function of the word index
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a >> 2) * 32'h9E37_79B1 + 32'h0BAD_F00D;
   endfunction

   assign i_in = rom_word(address);

   // drive one cycle of inputs, advance the model by the fetch rules, sample after the edge
   task automatic step(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] bt, input logic j, input logic [25:0] ji);
      logic [31:0] n_pc, n_instr, n_pp4;
      logic        n_valid;
      reset = r; stall = s; flush = f; branch_taken = b;
      branch_target = bt; jump = j; jump_index = ji;
      if (r) begin
         n_pc = 32'h0; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
      end else begin
         if (j)      n_pc = {m_pp4[31:28], ji, 2'b00};
         else if (b) n_pc = bt & 32'hFFFF_FFFC;
         else if (s) n_pc = m_pc;
         else        n_pc = m_pc + 32'd4;
         if (j || b || f) begin
            n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
         end else if (s) begin
            n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
         end else begin
            n_instr = rom_word(m_pc); n_pp4 = m_pc + 32'd4; n_valid = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 32'h0, 0, 26'h0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 32'h0, 0, 26'h0);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1), 26'($urandom));
         n_checks += 4;
         if (address !== 32'h0) $display("FAIL reset_addr got %h exp %h", address, 32'h0); else n_pass++;
         if (instr !== 32'h0) $display("FAIL reset_instr got %h exp %h", instr, 32'h0); else n_pass++;
         if (pc_plus4 !== 32'h0) $display("FAIL reset_pp4 got %h exp %h", pc_plus4, 32'h0); else n_pass++;
         if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else n_pass++;
      end
   endtask

   task automatic test_free_run();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         run(1);
         n_checks += 4;
         if (address !== 32'(4 * (k + 1))) $display("FAIL free_addr got %h exp %h", address, 32'(4 * (k + 1))); else n_pass++;
         if (instr !== rom_word(32'(4 * k))) $display("FAIL free_instr got %h exp %h", instr, rom_word(32'(4 * k))); else n_pass++;
         if (pc_plus4 !== 32'(4 * (k + 1))) $display("FAIL free_pp4 got %h exp %h", pc_plus4, 32'(4 * (k + 1))); else n_pass++;
         if (valid !== 1'b1) $display("FAIL free_valid got %b exp 1", valid); else n_pass++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      run(2);
      for (int k = 0; k < 2; k++) begin
         step(0, 1, 0, 0, 32'h0, 0, 26'h0);
         n_checks += 4;
         if (address !== 32'h8) $display("FAIL stall_addr got %h exp %h", address, 32'h8); else n_pass++;
         if (instr !== rom_word(32'h4)) $display("FAIL stall_instr got %h exp %h", instr, rom_word(32'h4)); else n_pass++;
         if (pc_plus4 !== 32'h8) $display("FAIL stall_pp4 got %h exp %h", pc_plus4, 32'h8); else n_pass++;
         if (valid !== 1'b1) $display("FAIL stall_valid got %b exp 1", valid); else n_pass++;
      end
      run(1);
      n_checks += 2;
      if (address !== 32'hC) $display("FAIL stall_release_addr got %h exp %h", address, 32'hC); else n_pass++;
      if (instr !== rom_word(32'h8)) $display("FAIL stall_release_instr got %h exp %h", instr, rom_word(32'h8)); else n_pass++;
   endtask

   task automatic test_branch();
      do_reset();
      run(4);
      step(0, $urandom_range(0, 1), 0, 1, 32'h0000_0043, 0, 26'h0);
      n_checks += 3;
      if (address !== 32'h40) $display("FAIL branch_addr got %h exp %h", address, 32'h40); else n_pass++;
      if (valid !== 1'b0) $display("FAIL branch_valid got %b exp 0", valid); else n_pass++;
      if (instr !== 32'h0) $display("FAIL branch_instr got %h exp 0", instr); else n_pass++;
      run(1);
      n_checks += 3;
      if (instr !== rom_word(32'h40)) $display("FAIL branch_target_instr got %h exp %h", instr, rom_word(32'h40)); else n_pass++;
      if (valid !== 1'b1) $display("FAIL branch_target_valid got %b exp 1", valid); else n_pass++;
      if (pc_plus4 !== 32'h44) $display("FAIL branch_target_pp4 got %h exp %h", pc_plus4, 32'h44); else n_pass++;
   endtask

   task automatic test_jump();
      do_reset();
      step(0, 0, 0, 1, 32'h1000_0004, 0, 26'h0);
      run(1);
      n_checks += 1;
      if (pc_plus4 !== 32'h1000_0008) $display("FAIL jump_setup_pp4 got %h exp %h", pc_plus4, 32'h1000_0008); else n_pass++;
      step(0, 0, 0, 1, 32'h0000_0200, 1, 26'h0000010);
      n_checks += 3;
      if (address !== 32'h1000_0040) $display("FAIL jump_addr got %h exp %h", address, 32'h1000_0040); else n_pass++;
      if (valid !== 1'b0) $display("FAIL jump_valid got %b exp 0", valid); else n_pass++;
      if (pc_plus4 !== 32'h0) $display("FAIL jump_pp4 got %h exp 0", pc_plus4); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      step(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 26'h0);
      run(1);
      n_checks += 4;
      if (address !== 32'h0) $display("FAIL wrap_addr got %h exp 0", address); else n_pass++;
      if (pc_plus4 !== 32'h0) $display("FAIL wrap_pp4 got %h exp 0", pc_plus4); else n_pass++;
      if (instr !== rom_word(32'hFFFF_FFFC)) $display("FAIL wrap_instr got %h exp %h", instr, rom_word(32'hFFFF_FFFC)); else n_pass++;
      if (valid !== 1'b1) $display("FAIL wrap_valid got %b exp 1", valid); else n_pass++;
   endtask

   task automatic test_flush();
      do_reset();
      run(2);
      step(0, 0, 1, 0, 32'h0, 0, 26'h0);
      n_checks += 2;
      if (address !== 32'hC) $display("FAIL flush_addr got %h exp %h", address, 32'hC); else n_pass++;
      if (valid !== 1'b0 || instr !== 32'h0) $display("FAIL flush_bubble got valid=%b instr=%h exp valid=0 instr=0", valid, instr); else n_pass++;
      run(1);
      step(0, 1, 1, 0, 32'h0, 0, 26'h0);
      n_checks += 2;
      if (address !== 32'h10) $display("FAIL flush_stall_addr got %h exp %h", address, 32'h10); else n_pass++;
      if (valid !== 1'b0 || pc_plus4 !== 32'h0) $display("FAIL flush_stall_bubble got valid=%b pp4=%h exp valid=0 pp4=0", valid, pc_plus4); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      run(3);
      step(1, 1, 0, 1, 32'h0000_0100, 0, 26'h0);
      n_checks += 3;
      if (address !== 32'h0) $display("FAIL midreset_addr got %h exp 0", address); else n_pass++;
      if (valid !== 1'b0) $display("FAIL midreset_valid got %b exp 0", valid); else n_pass++;
      if (instr !== 32'h0) $display("FAIL midreset_instr got %h exp 0", instr); else n_pass++;
      run(1);
      n_checks += 3;
      if (address !== 32'h4) $display("FAIL post_reset_addr got %h exp %h", address, 32'h4); else n_pass++;
      if (instr !== rom_word(32'h0)) $display("FAIL post_reset_instr got %h exp %h", instr, rom_word(32'h0)); else n_pass++;
      if (valid !== 1'b1) $display("FAIL post_reset_valid got %b exp 1", valid); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 19) == 0, 26'($urandom));
         n_checks++;
         if (address !== m_pc || instr !== m_instr || pc_plus4 !== m_pp4 || valid !== m_valid)
            $display("FAIL random cyc=%0d got a=%h i=%h p=%h v=%b exp a=%h i=%h p=%h v=%b",
                     k, address, instr, pc_plus4, valid, m_pc, m_instr, m_pp4, m_valid);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      test_reset();
      test_free_run();
      test_stall();
      test_branch();
      test_jump();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
